wait_state_sequencer: RTL and testbench
=======================================

// Module: wait_state_sequencer
// PURPOSE
//  Next-generation control sequencer for the basic processor: fetch/decode/execute FSM driving datapath bus and load strobes.
//  Adds a memory ready handshake with wait states, bus timeout with sticky error, a wider opcode space (BEQ, JMP, HALT) and a halted state.
//  Sits between the IR opcode field / ALU Z flag and the datapath and memory control inputs.
// PARAMETERS
//  WORD_W   8   datapath word width; passed through, no internal use beyond consistency
//  OP_W     4   opcode width; must be >= 4
//  TIMEOUT  15  max cycles to wait for mem_ready in a memory state; 0 = wait forever
// PORTS
//  clock      in   1     system clock, all state on posedge
//  reset      in   1     synchronous, active-high
//  z_flag     in   1     ALU zero flag
//  op         in   OP_W  opcode from IR: LOAD=0 STORE=1 ADD=2 SUB=3 XOR=4 INC=5 BNE=6 BEQ=7 JMP=8 HALT=15; other codes are NOPs
//  mem_ready  in   1     memory completes the access this cycle; sampled only while CS=1
//  ACC_bus, load_ACC, PC_bus, load_PC, load_IR, load_MAR, MDR_bus, load_MDR       out 1 each  datapath strobes
//  ALU_ACC, ALU_add, ALU_sub, ALU_xor, ALU_inc, INC_PC, Addr_bus                  out 1 each  ALU/PC controls
//  CS, R_NW   out  1     memory chip select; read(1)/write(0)
//  halted     out  1     1 in HALT or ERR state
//  bus_error  out  1     1 in ERR state only; sticky until reset
// BEHAVIOUR
//  Single clock domain. Synchronous active-high reset: next posedge with reset=1 puts the FSM in F0 and clears the timeout counter.
//  Outputs are combinational decode of state (and op in EXE). All outputs are 0 while reset=1. Unlisted outputs are 0 in every state.
//  States and transitions:
//   F0  PC_bus, load_MAR, INC_PC, load_PC                    -> F1
//   F1  CS, R_NW; hold until mem_ready                       -> F2 on mem_ready
//   F2  MDR_bus, load_IR                                     -> DEC
//   DEC Addr_bus, load_MAR                                   -> ST0 if STORE; HLT if HALT; F0 if NOP code; else RD
//   ST0 ACC_bus, load_MDR                                    -> ST1
//   ST1 CS (R_NW=0); hold until mem_ready                    -> F0
//   RD  CS, R_NW; hold until mem_ready                       -> LD for LOAD; EXE for ADD/SUB/XOR/INC
//       BNE: BR if z_flag=0, else F0; BEQ: BR if z_flag=1, else F0; JMP: BR
//       z_flag is sampled in the cycle mem_ready=1
//   LD  MDR_bus, load_ACC                                    -> F0
//   EXE MDR_bus, ALU_ACC, load_ACC, plus one of ALU_add/sub/xor/inc per op   -> F0
//   BR  MDR_bus, load_PC                                     -> F0
//   HLT halted=1, no strobes; stays until reset
//   ERR halted=1, bus_error=1, no strobes; stays until reset
//  Wait states: F1, ST1 and RD hold CS (and R_NW) stable for every cycle until mem_ready=1. With mem_ready tied 1, each takes exactly 1 cycle.
//   Instruction latency: LOAD/ALU/branch-taken 6 cycles; STORE 6; branch-not-taken 5.
//  Timeout: counter cleared on entry to each wait state and incremented every cycle there with mem_ready=0.
//   If TIMEOUT>0 and the count reaches TIMEOUT with mem_ready still 0 -> ERR on the next edge.
//   mem_ready=1 in the same cycle the count reaches TIMEOUT wins: normal advance, no error.
//  Counter width is $clog2(TIMEOUT+1), minimum 1. Counter saturates and never wraps.
//  Opcode: only op[OP_W-1:0] is decoded. With OP_W>4, the upper bits must be 0 for a code to match; otherwise it is a NOP.
//  Reset mid-wait: CS drops in the reset cycle. Neither sticky flag survives reset.
// TESTING
//  1  Reset, mem_ready=1, op=LOAD -> states F0,F1,F2,DEC,RD,LD,F0. load_ACC high exactly in cycle 6. CS high in cycles 2 and 5 only.
//  2  op=STORE, mem_ready held 0 for 3 cycles in ST1, then 1 -> CS=1/R_NW=0 for 4 consecutive cycles, then F0. bus_error stays 0.
//  3  op=BNE: z_flag=0 -> load_PC asserted in BR. z_flag=1 -> F0 after RD, no load_PC. Repeat with BEQ (inverted) and JMP (always BR).
//  4  TIMEOUT=15, mem_ready=0 forever in F1 -> ERR after 16 cycles in F1. halted=1, bus_error=1, all strobes 0. Reset returns to F0 with both flags 0.
//  5  mem_ready rises in the exact cycle the count hits TIMEOUT -> advances to F2, no ERR. TIMEOUT=0 with 100-cycle stall -> no ERR.
//  6  op=HALT -> HLT after DEC, halted=1 and persists 50 cycles. op=4'hA (NOP) -> DEC then F0, no memory access. Reset in mid-RD -> F0 next cycle.

Source files
------------

// File: rtl/wait_state_sequencer.sv
// Fetch/decode/execute control sequencer with memory wait states, bus timeout
// into a sticky error state, branch/jump/halt opcodes and a halted state.
module wait_state_sequencer #(
    parameter int WORD_W  = 8,
    parameter int OP_W    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            z_flag_i,
    input  logic [OP_W-1:0] op_i,
    input  logic            mem_ready_i,
    output logic            ACC_bus_o,
    output logic            load_ACC_o,
    output logic            PC_bus_o,
    output logic            load_PC_o,
    output logic            load_IR_o,
    output logic            load_MAR_o,
    output logic            MDR_bus_o,
    output logic            load_MDR_o,
    output logic            ALU_ACC_o,
    output logic            ALU_add_o,
    output logic            ALU_sub_o,
    output logic            ALU_xor_o,
    output logic            ALU_inc_o,
    output logic            INC_PC_o,
    output logic            Addr_bus_o,
    output logic            CS_o,
    output logic            R_NW_o,
    output logic            halted_o,
    output logic            bus_error_o
);

    if (OP_W < 4 || WORD_W < 1) begin : g_bad_param
        $error("wait_state_sequencer: OP_W must be >= 4 and WORD_W >= 1");
    end

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    typedef enum logic [3:0] {
        S_F0, S_F1, S_F2, S_DEC, S_ST0, S_ST1, S_RD,
        S_LD, S_EXE, S_BR, S_HLT, S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Full-width compare, so any set bit above the 4-bit code makes it a NOP.
    logic op_load, op_store, op_add, op_sub, op_xor, op_inc;
    logic op_bne, op_beq, op_jmp, op_halt, op_alu, op_br, op_rd;

    always_comb begin
        op_load  = (op_i == OP_W'(0));
        op_store = (op_i == OP_W'(1));
        op_add   = (op_i == OP_W'(2));
        op_sub   = (op_i == OP_W'(3));
        op_xor   = (op_i == OP_W'(4));
        op_inc   = (op_i == OP_W'(5));
        op_bne   = (op_i == OP_W'(6));
        op_beq   = (op_i == OP_W'(7));
        op_jmp   = (op_i == OP_W'(8));
        op_halt  = (op_i == OP_W'(15));
        op_alu   = op_add | op_sub | op_xor | op_inc;
        op_br    = op_bne | op_beq | op_jmp;
        op_rd    = op_load | op_alu | op_br;
    end

    logic wait_st, timeout_hit;

    always_comb begin
        wait_st     = (state_q == S_F1) || (state_q == S_ST1) || (state_q == S_RD);
        timeout_hit = (TIMEOUT != 0) && wait_st && !mem_ready_i && (cnt_q == TO_MAX);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_F0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_F0:  state_d = S_F1;
            S_F1:  if (mem_ready_i) state_d = S_F2;
            S_F2:  state_d = S_DEC;
            S_DEC: begin
                if (op_store)     state_d = S_ST0;
                else if (op_halt) state_d = S_HLT;
                else if (op_rd)   state_d = S_RD;
                else              state_d = S_F0;
            end
            S_ST0: state_d = S_ST1;
            S_ST1: if (mem_ready_i) state_d = S_F0;
            S_RD: begin
                if (mem_ready_i) begin
                    if (op_load)                  state_d = S_LD;
                    else if (op_alu)              state_d = S_EXE;
                    else if (op_jmp)              state_d = S_BR;
                    else if (op_bne && !z_flag_i) state_d = S_BR;
                    else if (op_beq && z_flag_i)  state_d = S_BR;
                    else                          state_d = S_F0;
                end
            end
            S_LD, S_EXE, S_BR: state_d = S_F0;
            S_HLT: state_d = S_HLT;
            S_ERR: state_d = S_ERR;
            default: state_d = S_F0;
        endcase
        if (timeout_hit) state_d = S_ERR;
    end

    // Count only while stalling in the same wait state; any other path
    // clears it, which also gives the clear-on-entry behaviour.
    always_comb begin
        cnt_d = '0;
        if (wait_st && !mem_ready_i && state_d == state_q)
            cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
    end

    always_comb begin
        ACC_bus_o   = 1'b0;
        load_ACC_o  = 1'b0;
        PC_bus_o    = 1'b0;
        load_PC_o   = 1'b0;
        load_IR_o   = 1'b0;
        load_MAR_o  = 1'b0;
        MDR_bus_o   = 1'b0;
        load_MDR_o  = 1'b0;
        ALU_ACC_o   = 1'b0;
        ALU_add_o   = 1'b0;
        ALU_sub_o   = 1'b0;
        ALU_xor_o   = 1'b0;
        ALU_inc_o   = 1'b0;
        INC_PC_o    = 1'b0;
        Addr_bus_o  = 1'b0;
        CS_o        = 1'b0;
        R_NW_o      = 1'b0;
        halted_o    = 1'b0;
        bus_error_o = 1'b0;
        if (!reset_i) begin
            unique case (state_q)
                S_F0: begin
                    PC_bus_o   = 1'b1;
                    load_MAR_o = 1'b1;
                    INC_PC_o   = 1'b1;
                    load_PC_o  = 1'b1;
                end
                S_F1, S_RD: begin
                    CS_o   = 1'b1;
                    R_NW_o = 1'b1;
                end
                S_F2: begin
                    MDR_bus_o = 1'b1;
                    load_IR_o = 1'b1;
                end
                S_DEC: begin
                    Addr_bus_o = 1'b1;
                    load_MAR_o = 1'b1;
                end
                S_ST0: begin
                    ACC_bus_o  = 1'b1;
                    load_MDR_o = 1'b1;
                end
                S_ST1: CS_o = 1'b1;
                S_LD: begin
                    MDR_bus_o  = 1'b1;
                    load_ACC_o = 1'b1;
                end
                S_EXE: begin
                    MDR_bus_o  = 1'b1;
                    ALU_ACC_o  = 1'b1;
                    load_ACC_o = 1'b1;
                    ALU_add_o  = op_add;
                    ALU_sub_o  = op_sub;
                    ALU_xor_o  = op_xor;
                    ALU_inc_o  = op_inc;
                end
                S_BR: begin
                    MDR_bus_o = 1'b1;
                    load_PC_o = 1'b1;
                end
                S_HLT: halted_o = 1'b1;
                S_ERR: begin
                    halted_o    = 1'b1;
                    bus_error_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wait_state_sequencer.sv
// Scoreboard bench: stimulus pushes the expected output word for each cycle,
// a negedge monitor pops and compares against the DUT outputs.
module tb_wait_state_sequencer;
    // Output word bit positions
    localparam int B_HALT = 18, B_BERR = 17, B_CS = 16, B_RNW = 15, B_ACCB = 14;
    localparam int B_LACC = 13, B_PCB = 12, B_LPC = 11, B_LIR = 10, B_LMAR = 9;
    localparam int B_MDRB = 8, B_LMDR = 7, B_ALUACC = 6, B_ADD = 5, B_SUB = 4;
    localparam int B_XOR = 3, B_INC = 2, B_INCPC = 1, B_ADDR = 0;

    localparam logic [18:0] E_RST = 19'd0;
    localparam logic [18:0] E_F0  = 19'((1 << B_PCB) | (1 << B_LMAR) | (1 << B_INCPC) | (1 << B_LPC));
    localparam logic [18:0] E_F1  = 19'((1 << B_CS) | (1 << B_RNW));
    localparam logic [18:0] E_F2  = 19'((1 << B_MDRB) | (1 << B_LIR));
    localparam logic [18:0] E_DEC = 19'((1 << B_ADDR) | (1 << B_LMAR));
    localparam logic [18:0] E_ST0 = 19'((1 << B_ACCB) | (1 << B_LMDR));
    localparam logic [18:0] E_ST1 = 19'(1 << B_CS);
    localparam logic [18:0] E_RD  = 19'((1 << B_CS) | (1 << B_RNW));
    localparam logic [18:0] E_LD  = 19'((1 << B_MDRB) | (1 << B_LACC));
    localparam logic [18:0] E_EXE = 19'((1 << B_MDRB) | (1 << B_ALUACC) | (1 << B_LACC));
    localparam logic [18:0] E_BR  = 19'((1 << B_MDRB) | (1 << B_LPC));
    localparam logic [18:0] E_HLT = 19'(1 << B_HALT);
    localparam logic [18:0] E_ERR = 19'((1 << B_HALT) | (1 << B_BERR));

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       z   = 1'b0;
    logic       mr  = 1'b1;
    logic [3:0] op  = 4'd0;
    wire [18:0] o_a, o_b;

    always #5 clk = ~clk;

    wait_state_sequencer #(.WORD_W(8), .OP_W(4), .TIMEOUT(15)) u_dut (
        .clock_i(clk), .reset_i(rst), .z_flag_i(z), .op_i(op), .mem_ready_i(mr),
        .ACC_bus_o(o_a[B_ACCB]), .load_ACC_o(o_a[B_LACC]), .PC_bus_o(o_a[B_PCB]),
        .load_PC_o(o_a[B_LPC]), .load_IR_o(o_a[B_LIR]), .load_MAR_o(o_a[B_LMAR]),
        .MDR_bus_o(o_a[B_MDRB]), .load_MDR_o(o_a[B_LMDR]), .ALU_ACC_o(o_a[B_ALUACC]),
        .ALU_add_o(o_a[B_ADD]), .ALU_sub_o(o_a[B_SUB]), .ALU_xor_o(o_a[B_XOR]),
        .ALU_inc_o(o_a[B_INC]), .INC_PC_o(o_a[B_INCPC]), .Addr_bus_o(o_a[B_ADDR]),
        .CS_o(o_a[B_CS]), .R_NW_o(o_a[B_RNW]), .halted_o(o_a[B_HALT]),
        .bus_error_o(o_a[B_BERR])
    );

    wait_state_sequencer #(.WORD_W(8), .OP_W(4), .TIMEOUT(0)) u_dut_nt (
        .clock_i(clk), .reset_i(rst), .z_flag_i(z), .op_i(op), .mem_ready_i(mr),
        .ACC_bus_o(o_b[B_ACCB]), .load_ACC_o(o_b[B_LACC]), .PC_bus_o(o_b[B_PCB]),
        .load_PC_o(o_b[B_LPC]), .load_IR_o(o_b[B_LIR]), .load_MAR_o(o_b[B_LMAR]),
        .MDR_bus_o(o_b[B_MDRB]), .load_MDR_o(o_b[B_LMDR]), .ALU_ACC_o(o_b[B_ALUACC]),
        .ALU_add_o(o_b[B_ADD]), .ALU_sub_o(o_b[B_SUB]), .ALU_xor_o(o_b[B_XOR]),
        .ALU_inc_o(o_b[B_INC]), .INC_PC_o(o_b[B_INCPC]), .Addr_bus_o(o_b[B_ADDR]),
        .CS_o(o_b[B_CS]), .R_NW_o(o_b[B_RNW]), .halted_o(o_b[B_HALT]),
        .bus_error_o(o_b[B_BERR])
    );

    typedef struct {
        string       name;
        logic [18:0] ea;
        logic [18:0] eb;
        bit          chkb;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    // Monitor: outputs are combinational, so every cycle presents a word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if (o_a === e.ea) passed++;
                else $display("FAIL %s: got %b want %b", e.name, o_a, e.ea);
                if (e.chkb) begin
                    total++;
                    if (o_b === e.eb) passed++;
                    else $display("FAIL %s(timeout=0): got %b want %b", e.name, o_b, e.eb);
                end
            end
        end
    end

    task automatic cyc2(input logic r, input logic [3:0] o, input logic zz, input logic m,
                        input logic [18:0] ea, input logic [18:0] eb, input bit chkb,
                        input string nm);
        exp_t e;
        @(posedge clk);
        #2;
        rst = r; op = o; z = zz; mr = m;
        e.name = nm; e.ea = ea; e.eb = eb; e.chkb = chkb;
        sb.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic [3:0] o, input logic zz, input logic m,
                       input logic [18:0] ea, input string nm);
        cyc2(r, o, zz, m, ea, E_RST, 1'b0, nm);
    endtask

    task automatic fetch(input logic [3:0] o, input string nm);
        cyc(0, o, 0, 1, E_F0,  {nm, "_F0"});
        cyc(0, o, 0, 1, E_F1,  {nm, "_F1"});
        cyc(0, o, 0, 1, E_F2,  {nm, "_F2"});
        cyc(0, o, 0, 1, E_DEC, {nm, "_DEC"});
    endtask

    initial begin
        logic [18:0] alu_bit [4];
        alu_bit[0] = 19'(1 << B_ADD);
        alu_bit[1] = 19'(1 << B_SUB);
        alu_bit[2] = 19'(1 << B_XOR);
        alu_bit[3] = 19'(1 << B_INC);

        // Reset: all outputs low on both instances
        cyc2(1, 4'd0, 0, 1, E_RST, E_RST, 1'b1, "reset0");
        cyc2(1, 4'd0, 0, 1, E_RST, E_RST, 1'b1, "reset1");

        // LOAD with zero wait states
        fetch(4'd0, "load");
        cyc(0, 4'd0, 0, 1, E_RD, "load_RD");
        cyc(0, 4'd0, 0, 1, E_LD, "load_LD");

        // ALU ops each pick their own ALU select in EXE
        for (int k = 0; k < 4; k++) begin
            fetch(4'(k + 2), "alu");
            cyc(0, 4'(k + 2), 0, 1, E_RD, "alu_RD");
            cyc(0, 4'(k + 2), 0, 1, E_EXE | alu_bit[k], "alu_EXE");
        end

        // STORE with three wait states in ST1
        fetch(4'd1, "store");
        cyc(0, 4'd1, 0, 1, E_ST0, "store_ST0");
        for (int i = 0; i < 3; i++) cyc(0, 4'd1, 0, 0, E_ST1, "store_ST1_wait");
        cyc(0, 4'd1, 0, 1, E_ST1, "store_ST1_rdy");

        // Branches: BNE, BEQ, JMP both flag polarities
        fetch(4'd6, "bne_nz"); cyc(0, 4'd6, 0, 1, E_RD, "bne_nz_RD"); cyc(0, 4'd6, 0, 1, E_BR, "bne_nz_BR");
        fetch(4'd6, "bne_z");  cyc(0, 4'd6, 1, 1, E_RD, "bne_z_RD");
        fetch(4'd7, "beq_z");  cyc(0, 4'd7, 1, 1, E_RD, "beq_z_RD");  cyc(0, 4'd7, 0, 1, E_BR, "beq_z_BR");
        fetch(4'd7, "beq_nz"); cyc(0, 4'd7, 0, 1, E_RD, "beq_nz_RD");
        fetch(4'd8, "jmp0");   cyc(0, 4'd8, 0, 1, E_RD, "jmp0_RD");   cyc(0, 4'd8, 0, 1, E_BR, "jmp0_BR");
        fetch(4'd8, "jmp1");   cyc(0, 4'd8, 1, 1, E_RD, "jmp1_RD");   cyc(0, 4'd8, 1, 1, E_BR, "jmp1_BR");

        // Timeout: 16 stalled cycles in F1 then sticky ERR
        cyc(0, 4'd0, 0, 1, E_F0, "to_F0");
        for (int i = 0; i < 16; i++) cyc(0, 4'd0, 0, 0, E_F1, "to_F1_wait");
        for (int i = 0; i < 3; i++)  cyc(0, 4'd0, 0, 0, E_ERR, "to_ERR");
        cyc(0, 4'd0, 0, 1, E_ERR, "to_ERR_rdy");
        cyc(1, 4'd0, 0, 1, E_RST, "to_reset");
        cyc(0, 4'd0, 0, 1, E_F0, "to_after_reset");

        // Ready arrives exactly as the count reaches TIMEOUT; RD counter starts fresh
        for (int i = 0; i < 15; i++) cyc(0, 4'd0, 0, 0, E_F1, "edge_F1_wait");
        cyc(0, 4'd0, 0, 1, E_F1, "edge_F1_rdy");
        cyc(0, 4'd0, 0, 1, E_F2, "edge_F2");
        cyc(0, 4'd0, 0, 1, E_DEC, "edge_DEC");
        for (int i = 0; i < 15; i++) cyc(0, 4'd0, 0, 0, E_RD, "edge_RD_wait");
        cyc(0, 4'd0, 0, 1, E_RD, "edge_RD_rdy");
        cyc(0, 4'd0, 0, 1, E_LD, "edge_LD");

        // TIMEOUT=0 instance rides out a 100-cycle stall
        cyc2(1, 4'd0, 0, 1, E_RST, E_RST, 1'b1, "nt_reset");
        cyc2(0, 4'd0, 0, 1, E_F0, E_F0, 1'b1, "nt_F0");
        for (int i = 0; i < 100; i++)
            cyc2(0, 4'd0, 0, 0, (i < 16) ? E_F1 : E_ERR, E_F1, 1'b1, "nt_stall");
        cyc2(0, 4'd0, 0, 1, E_ERR, E_F1, 1'b1, "nt_rdy");
        cyc2(0, 4'd0, 0, 1, E_ERR, E_F2, 1'b1, "nt_F2");
        cyc2(1, 4'd0, 0, 1, E_RST, E_RST, 1'b1, "nt_reset2");

        // HALT persists regardless of inputs
        fetch(4'd15, "halt");
        for (int i = 0; i < 50; i++) cyc(0, 4'd15, i[0], i[1], E_HLT, "halt_HLT");
        cyc(1, 4'd15, 0, 1, E_RST, "halt_reset");

        // NOP code goes straight back to fetch
        fetch(4'hA, "nop");
        cyc(0, 4'hA, 0, 1, E_F0, "nop_F0");
        cyc(0, 4'hA, 0, 1, E_F1, "nop_F1");

        // Reset in the middle of an RD wait
        cyc(0, 4'd0, 0, 1, E_F2, "mid_F2");
        cyc(0, 4'd0, 0, 1, E_DEC, "mid_DEC");
        cyc(0, 4'd0, 0, 0, E_RD, "mid_RD0");
        cyc(0, 4'd0, 0, 0, E_RD, "mid_RD1");
        cyc(1, 4'd0, 0, 0, E_RST, "mid_reset");
        cyc(0, 4'd0, 0, 1, E_F0, "mid_F0");
        cyc(0, 4'd0, 0, 1, E_F1, "mid_F1");

        repeat (3) @(posedge clk);
        total++;
        if (sb.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending want 0", sb.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
